// File: rtl/relu_pool_sipo_layer.sv
// relu_pool_sipo_layer
// Serial-in, parallel-out ReLU + max-pool layer. Accepts one signed word per
// valid/ready transfer, clamps negatives to zero, takes the max over each run
// of POOL_SIZE words and stores it in the next slot of a packed output vector.
// When all OUTPUT_LAYER_HEIGHT windows are written the frame is presented on
// data_o with valid_o until the consumer pulses yumi_i.
//
// Ports
//   clk_i    : clock, rising edge
//   reset_i  : asynchronous active-low reset
//   valid_i  : upstream word valid
//   ready_o  : block accepts a word this cycle (registered)
//   data_i   : signed input sample, WORD_SIZE bits
//   valid_o  : pooled frame available on data_o (registered)
//   yumi_i   : downstream consumes the frame (only honoured while valid_o=1)
//   data_o   : OUTPUT_LAYER_HEIGHT x WORD_SIZE pooled vector, element 0 first

module relu_pool_sipo_layer #(
  parameter int unsigned WORD_SIZE           = 16,
  parameter int unsigned POOL_SIZE           = 2,
  parameter int unsigned OUTPUT_LAYER_HEIGHT = 8
) (
  input  logic                                               clk_i,
  input  logic                                               reset_i,
  input  logic                                               valid_i,
  output logic                                               ready_o,
  input  logic signed [WORD_SIZE-1:0]                        data_i,
  output logic                                               valid_o,
  input  logic                                               yumi_i,
  output logic signed [OUTPUT_LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_o
);

  localparam int unsigned PC_W = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int unsigned WI_W = (OUTPUT_LAYER_HEIGHT > 1) ? $clog2(OUTPUT_LAYER_HEIGHT) : 1;
  localparam logic [PC_W-1:0] POOL_LAST = PC_W'(POOL_SIZE - 1);
  localparam logic [WI_W-1:0] WIN_LAST  = WI_W'(OUTPUT_LAYER_HEIGHT - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_e;

  state_e                                              state_q, state_d;
  logic [PC_W-1:0]                                     pool_q, pool_d;
  logic [WI_W-1:0]                                     win_q, win_d;
  logic signed [WORD_SIZE-1:0]                         max_q, max_d;
  logic signed [OUTPUT_LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_q, data_d;
  logic                                                ready_q, ready_d;
  logic                                                valid_q, valid_d;

  logic signed [WORD_SIZE-1:0] relu_c;
  logic signed [WORD_SIZE-1:0] pooled_c;
  logic                        xfer_c;

  // ReLU on the incoming word and running max including it
  always_comb begin
    relu_c   = data_i[WORD_SIZE-1] ? '0 : data_i;
    pooled_c = (relu_c > max_q) ? relu_c : max_q;
    // ready_q is low for the partial cycle after reset release, so gate on it
    xfer_c   = valid_i && ready_q && (state_q == COLLECT);
  end

  // Next-state and next-output computation
  always_comb begin
    state_d = state_q;
    pool_d  = pool_q;
    win_d   = win_q;
    max_d   = max_q;
    data_d  = data_q;

    unique case (state_q)
      COLLECT: begin
        if (xfer_c) begin
          max_d = (pool_q == '0) ? relu_c : pooled_c;
          if (pool_q == POOL_LAST) begin
            data_d[win_q] = pooled_c;
            pool_d        = '0;
            if (win_q == WIN_LAST) begin
              win_d   = '0;
              state_d = DONE;
            end else begin
              win_d = win_q + WI_W'(1);
            end
          end else begin
            pool_d = pool_q + PC_W'(1);
          end
        end
      end
      DONE: begin
        if (yumi_i) begin
          state_d = COLLECT;
          pool_d  = '0;
          win_d   = '0;
        end
      end
      default: state_d = COLLECT;
    endcase

    ready_d = (state_d == COLLECT);
    valid_d = (state_d == DONE);
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= COLLECT;
      pool_q  <= '0;
      win_q   <= '0;
      max_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pool_q  <= pool_d;
      win_q   <= win_d;
      max_q   <= max_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_relu_pool_sipo_layer.sv
// Testbench for relu_pool_sipo_layer (WORD_SIZE=16, POOL_SIZE=2, height 4).
// Expected frames are computed from the stimulus and queued; they are popped
// and compared when the DUT presents a frame.

module tb_relu_pool_sipo_layer;

  localparam int unsigned W = 16;
  localparam int unsigned P = 2;
  localparam int unsigned H = 4;
  localparam int unsigned N = P * H;

  logic                    clk = 1'b0;
  logic                    reset_i;
  logic                    valid_i;
  logic                    ready_o;
  logic signed [W-1:0]     data_i;
  logic                    valid_o;
  logic                    yumi_i;
  logic signed [H-1:0][W-1:0] data_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [H*W-1:0] sb[$];
  logic [H*W-1:0] last_exp;

  logic [W-1:0] basic_f [N];
  logic [W-1:0] neg_f   [N];
  logic [W-1:0] rnd_f   [N];

  always #5 clk = ~clk;

  relu_pool_sipo_layer #(
    .WORD_SIZE(W),
    .POOL_SIZE(P),
    .OUTPUT_LAYER_HEIGHT(H)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i(data_i),
    .valid_o(valid_o),
    .yumi_i(yumi_i),
    .data_o(data_o)
  );

  function automatic logic [W-1:0] relu(input logic [W-1:0] x);
    return x[W-1] ? '0 : x;
  endfunction

  function automatic logic [H*W-1:0] model(input logic [W-1:0] w [N]);
    logic [H*W-1:0] r;
    logic [W-1:0]   m;
    r = '0;
    for (int k = 0; k < H; k++) begin
      m = relu(w[k*P]);
      for (int j = 1; j < P; j++)
        if ($signed(relu(w[k*P+j])) > $signed(m)) m = relu(w[k*P+j]);
      r[k*W +: W] = m;
    end
    return r;
  endfunction

  // Drive a full frame through the handshake, then check the presented result
  task automatic send_frame(input logic [W-1:0] w [N], input bit bubbly,
                            input bit yumi_level, input string name);
    int  i = 0;
    int  cyc = 0;
    bit  xfer;
    logic [H*W-1:0] exp_v;
    sb.push_back(model(w));
    while (i < N && cyc < 200) begin
      @(negedge clk);
      cyc++;
      yumi_i = yumi_level;
      if (bubbly && $urandom_range(0, 2) == 0) begin
        valid_i = 1'b0;
        data_i  = W'($urandom);
      end else begin
        valid_i = 1'b1;
        data_i  = w[i];
      end
      xfer = valid_i && ready_o;
      @(posedge clk);
      if (xfer) i++;
    end
    @(negedge clk);
    valid_i = 1'b0;
    n_cmp++;
    if (i != N) begin
      n_err++;
      $display("FAIL %s timeout: transfers=%0d required=%0d", name, i, N);
    end
    if (!bubbly) begin
      n_cmp++;
      if (cyc != N) begin
        n_err++;
        $display("FAIL %s cycles: got=%0d required=%0d", name, cyc, N);
      end
    end
    n_cmp++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s handshake: valid_o=%b ready_o=%b required 1/0", name, valid_o, ready_o);
    end
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      exp_v    = sb.pop_front();
      last_exp = exp_v;
      n_cmp++;
      if (data_o !== exp_v) begin
        n_err++;
        $display("FAIL %s data_o: got=%h required=%h", name, data_o, exp_v);
      end
    end
  endtask

  task automatic consume(input string name);
    @(negedge clk);
    yumi_i = 1'b1;
    @(negedge clk);
    yumi_i = 1'b0;
    n_cmp++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s consume: valid_o=%b ready_o=%b required 0/1", name, valid_o, ready_o);
    end
    n_cmp++;
    if (data_o !== last_exp) begin
      n_err++;
      $display("FAIL %s retain: got=%h required=%h", name, data_o, last_exp);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    valid_i = 1'b0;
    yumi_i  = 1'b0;
    data_i  = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0 || data_o !== '0) begin
      n_err++;
      $display("FAIL reset_state: valid_o=%b ready_o=%b data_o=%h required 0/0/0", valid_o, ready_o, data_o);
    end
    reset_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: ready_o=%b valid_o=%b required 1/0", ready_o, valid_o);
    end
  endtask

  task automatic test_basic();
    send_frame(basic_f, 1'b0, 1'b0, "basic");
    n_cmp++;
    if (data_o !== {16'h7FFF, 16'h0001, 16'h0030, 16'h0020}) begin
      n_err++;
      $display("FAIL basic_const: got=%h required=7fff000100300020", data_o);
    end
    consume("basic");
  endtask

  task automatic test_all_negative();
    send_frame(neg_f, 1'b0, 1'b0, "all_neg");
    consume("all_neg");
  endtask

  task automatic test_backpressure();
    send_frame(rnd_f, 1'b0, 1'b0, "bp_frame");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = W'($urandom);
      yumi_i  = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || data_o !== last_exp) begin
        n_err++;
        $display("FAIL backpressure cycle %0d: valid_o=%b ready_o=%b data_o=%h required 1/0/%h",
                 c, valid_o, ready_o, data_o, last_exp);
      end
    end
    valid_i = 1'b0;
    consume("bp");
    send_frame(basic_f, 1'b0, 1'b0, "bp_next");
    consume("bp_next");
  endtask

  task automatic test_bubbly();
    send_frame(basic_f, 1'b1, 1'b0, "bubbly");
    consume("bubbly");
  endtask

  task automatic test_reset_mid_frame();
    int i = 0;
    int cyc = 0;
    bit xfer;
    while (i < 5 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      valid_i = 1'b1;
      data_i  = rnd_f[i];
      xfer    = ready_o;
      @(posedge clk);
      if (xfer) i++;
    end
    @(negedge clk);
    valid_i = 1'b0;
    #2 reset_i = 1'b0;
    #1;
    n_cmp++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0 || data_o !== '0) begin
      n_err++;
      $display("FAIL mid_reset: valid_o=%b ready_o=%b data_o=%h required 0/0/0", valid_o, ready_o, data_o);
    end
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    send_frame(basic_f, 1'b0, 1'b0, "after_reset");
    consume("after_reset");
  endtask

  task automatic test_spurious_yumi();
    send_frame(rnd_f, 1'b0, 1'b1, "spurious_yumi");
    consume("spurious_yumi");
  endtask

  task automatic test_back_to_back();
    send_frame(neg_f, 1'b0, 1'b0, "b2b_a");
    consume("b2b_a");
    send_frame(basic_f, 1'b0, 1'b0, "b2b_b");
    consume("b2b_b");
  endtask

  initial begin
    basic_f = '{16'h0010, 16'h0020, 16'h0030, 16'h0005,
                16'hFFF0, 16'h0001, 16'h7FFF, 16'h0000};
    neg_f   = '{16'h8000, 16'hA000, 16'hC000, 16'hE000,
                16'hF000, 16'hFFF0, 16'hFFFE, 16'hFFFF};
    rnd_f   = '{16'h1234, 16'h8001, 16'h0F00, 16'h0F00,
                16'hFFFF, 16'h0002, 16'h4000, 16'h3FFF};
    last_exp = '0;

    test_reset();
    test_basic();
    test_all_negative();
    test_backpressure();
    test_bubbly();
    test_reset_mid_frame();
    test_spurious_yumi();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/relu_pool_sipo_layer.md
RELU_POOL_SIPO_LAYER -- requirements
Module: relu_pool_sipo_layer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16: bit width of each signed fixed-point sample.
REQ-002 SHALL have parameter POOL_SIZE, default 2: number of consecutive input samples per max-pool window (>=2).
REQ-003 SHALL have parameter OUTPUT_LAYER_HEIGHT, default 8: pooled words per frame; frame length is N = OUTPUT_LAYER_HEIGHT*POOL_SIZE input words.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_i  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port valid_i  input  1  upstream serial word valid.
REQ-007 SHALL have port ready_o  output  1  block can accept a word this cycle (helpful handshake).
REQ-008 SHALL have port data_i  input  WORD_SIZE  signed serial sample from the upstream serializer.
REQ-009 SHALL have port valid_o  output  1  complete pooled frame on data_o.
REQ-010 SHALL have port yumi_i  input  1  downstream consumes the frame (demanding handshake, legal only while valid_o=1).
REQ-011 SHALL have port data_o  output  OUTPUT_LAYER_HEIGHT x WORD_SIZE  signed packed pooled vector, element 0 = first window.

Function
REQ-012 SHALL implement two states: COLLECT and DONE.
REQ-013 SHALL drive ready_o=1 and valid_o=0 in COLLECT; ready_o=0 and valid_o=1 in DONE (both registered-state decodes, no combinational path from valid_i or yumi_i).
REQ-014 SHALL transfer a word only on a cycle where valid_i=1 and ready_o=1; no other cycle changes counters or accumulator.
REQ-015 SHALL apply ReLU to each accepted word: signed value <0 becomes 0, otherwise unchanged.
REQ-016 SHALL keep a pool counter 0..POOL_SIZE-1 and a window index 0..OUTPUT_LAYER_HEIGHT-1, both advanced on each transfer, pool counter wrapping to 0 and incrementing the window index.
REQ-017 SHALL load the running max with the ReLU result on pool count 0, and on later counts load max(running max, ReLU result) using signed comparison; ties keep the value (identical either way).
REQ-018 SHALL, on the transfer with pool count POOL_SIZE-1, write max(running max, ReLU result) into data_o[window index] in the same edge.
REQ-019 SHALL, on the transfer with pool count POOL_SIZE-1 and window index OUTPUT_LAYER_HEIGHT-1, move to DONE, so valid_o rises the cycle after the final transfer (latency 1 cycle).
REQ-020 SHALL sustain one transfer per cycle in COLLECT with valid_i held high (N cycles per frame, no bubbles).
REQ-021 SHALL, in DONE, hold data_o and valid_o stable until yumi_i=1; on that edge return to COLLECT with both counters 0, ready_o=1 the next cycle.
REQ-022 SHALL ignore yumi_i in COLLECT and ignore valid_i in DONE (no data loss: upstream stalls via ready_o=0).
REQ-023 SHALL retain data_o contents after yumi_i; elements are overwritten window-by-window by the next frame.
REQ-024 SHALL never saturate or round: output is always one of the ReLU'd input values, width WORD_SIZE.

Reset
REQ-025 SHALL, while reset_i=0 (asynchronously, regardless of clock), force state COLLECT, both counters 0, running max 0, all data_o elements 0, valid_o=0; ready_o=0 during reset, 1 the first cycle after release.
REQ-026 SHALL discard any partial frame when reset asserts mid-operation; the first transfer after release is window 0, pool count 0.

Verification (WORD_SIZE=16, POOL_SIZE=2, OUTPUT_LAYER_HEIGHT=4)
REQ-027 SHALL cover basic frame: stream 0x0010,0x0020,0x0030,0x0005,0xFFF0,0x0001,0x7FFF,0x0000 back-to-back -> valid_o one cycle after 8th transfer, data_o = {0x0020,0x0030,0x0001,0x7FFF}, ready_o=0.
REQ-028 SHALL cover all-negative frame: eight words 0x8000..0xFFFF -> data_o all 0x0000, valid_o=1.
REQ-029 SHALL cover backpressure: hold yumi_i=0 for 20 cycles with valid_i=1 and new data -> data_o and valid_o unchanged, no transfers; yumi_i pulse -> valid_o=0, ready_o=1 next cycle, next frame's results correct.
REQ-030 SHALL cover bubbly input: valid_i toggled pseudo-randomly mid-window -> same data_o as back-to-back run of REQ-027 values.
REQ-031 SHALL cover reset mid-frame: assert reset_i=0 asynchronously after 5 transfers -> valid_o=0, data_o all 0 immediately; after release, a full REQ-027 frame gives the REQ-027 result.
REQ-032 SHALL cover spurious yumi_i in COLLECT: yumi_i=1 for whole frame except DONE handling -> counters unaffected, frame completes normally and is consumed on first DONE cycle.
